vga_key_mode_ctrl: RTL and testbench

Upstream control stage for the VGA picture display top. It debounces the two active-low board keys (key[1:0]) on the 50 MHz pixel-domain clock and emits one-cycle press pulses. It keeps a picture-mode index that the keys step up and down, with wrap-around. The new mode reaches the display only at a frame boundary, so a picture never changes mid-frame.

---
 rtl/vga_key_mode_ctrl.sv | 157 +++++++++++++++
 tb/tb_vga_key_mode_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_key_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_key_mode_ctrl : key debounce plus frame-aligned picture-mode selection |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_key_mode_ctrl #(
  parameter int CNT_MAX    = 1000000,
  parameter int MODE_NUM   = 4,
  parameter int MODE_W     = 2,
  parameter bit FRAME_SYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        key,
  input  logic              frame_start,
  output logic [1:0]        key_level,
  output logic [1:0]        key_press,
  output logic [MODE_W-1:0] mode,
  output logic [MODE_W-1:0] mode_pend,
  output logic              mode_upd
);

  localparam int                CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_PRESS_FILT = 2'd1;
  localparam logic [1:0] S_DOWN       = 2'd2;
  localparam logic [1:0] S_REL_FILT   = 2'd3;

  // Synchronizers reset to the released level so reset never fakes a press.
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_key
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             level;
    logic             ks;

    assign ks = sync2_q[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_IDLE: begin
          if (!ks) begin
            state_d = S_PRESS_FILT;
            cnt_d   = '0;
          end
        end
        S_PRESS_FILT: begin
          if (ks) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_DOWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DOWN: begin
          if (ks) begin
            state_d = S_REL_FILT;
            cnt_d   = '0;
          end
        end
        S_REL_FILT: begin
          if (!ks) begin
            state_d = S_DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Only a completed press filter pulses; a release bounce back to DOWN does not.
    always_comb begin
      level   = (state_q == S_DOWN) || (state_q == S_REL_FILT);
      press_d = (state_q == S_PRESS_FILT) && (state_d == S_DOWN);
    end

    assign key_level[i] = level;
    assign key_press[i] = press_q;
  end

  logic [MODE_W-1:0] mode_pend_q, mode_pend_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_upd_q, mode_upd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_pend_q <= '0;
      mode_q      <= '0;
      mode_upd_q  <= 1'b0;
    end else begin
      mode_pend_q <= mode_pend_d;
      mode_q      <= mode_d;
      mode_upd_q  <= mode_upd_d;
    end
  end

  always_comb begin
    mode_pend_d = mode_pend_q;
    case (key_press)
      2'b01:   mode_pend_d = (mode_pend_q == MODE_LAST) ? '0 : mode_pend_q + MODE_W'(1);
      2'b10:   mode_pend_d = (mode_pend_q == '0) ? MODE_LAST : mode_pend_q - MODE_W'(1);
      default: mode_pend_d = mode_pend_q;
    endcase

    // A pend update coinciding with frame_start lands on the following frame.
    if (FRAME_SYNC) begin
      mode_d = frame_start ? mode_pend_q : mode_q;
    end else begin
      mode_d = mode_pend_q;
    end
    mode_upd_d = (mode_d != mode_q);
  end

  assign mode      = mode_q;
  assign mode_pend = mode_pend_q;
  assign mode_upd  = mode_upd_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_key_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_key_mode_ctrl : directed bench, one free-running and one            |
// | frame-synchronised instance sharing clock and reset                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_key_mode_ctrl;

  localparam int CNT_MAX  = 10;
  localparam int MODE_NUM = 4;
  localparam int MODE_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              fs;
  logic [1:0]        key0, key1;
  logic [1:0]        kl0, kp0, kl1, kp1;
  logic [MODE_W-1:0] m0, mp0, m1, mp1;
  logic              mu0, mu1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_key_mode_ctrl #(
    .CNT_MAX(CNT_MAX), .MODE_NUM(MODE_NUM), .MODE_W(MODE_W), .FRAME_SYNC(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .key(key0), .frame_start(fs),
    .key_level(kl0), .key_press(kp0), .mode(m0), .mode_pend(mp0), .mode_upd(mu0)
  );

  vga_key_mode_ctrl #(
    .CNT_MAX(CNT_MAX), .MODE_NUM(MODE_NUM), .MODE_W(MODE_W), .FRAME_SYNC(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .key(key1), .frame_start(fs),
    .key_level(kl1), .key_press(kp1), .mode(m1), .mode_pend(mp1), .mode_upd(mu1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_level0"}, kl0, 2'b00);
    check({tag, "_press0"}, kp0, 2'b00);
    check({tag, "_mode0"},  m0,  2'd0);
    check({tag, "_pend0"},  mp0, 2'd0);
    check({tag, "_upd0"},   {1'b0, mu0}, 2'b00);
    check({tag, "_mode1"},  m1,  2'd0);
    check({tag, "_pend1"},  mp1, 2'd0);
  endtask

  // Release both keys and wait out the release filter; no pulse may appear.
  task automatic release_keys(input string tag);
    key0 = 2'b11;
    key1 = 2'b11;
    for (int i = 0; i < 15; i++) begin
      step();
      check({tag, "_rel_press0"}, kp0, 2'b00);
      check({tag, "_rel_press1"}, kp1, 2'b00);
    end
    check({tag, "_rel_level0"}, kl0, 2'b00);
    check({tag, "_rel_level1"}, kl1, 2'b00);
  endtask

  // Hold k from the current edge N: pulse expected at N+13, pend at N+14.
  task automatic press(input bit which, input logic [1:0] k, input logic [1:0] exp_press,
                       input logic [1:0] exp_pend, input string tag);
    if (which) key1 = k;
    else       key0 = k;
    for (int i = 1; i <= 12; i++) begin
      step();
      check({tag, "_early"}, which ? kp1 : kp0, 2'b00);
    end
    step();
    check({tag, "_press"}, which ? kp1 : kp0, exp_press);
    step();
    check({tag, "_pend"}, which ? mp1 : mp0, exp_pend);
    release_keys(tag);
  endtask

  initial begin
    rst  = 1'b1;
    fs   = 1'b0;
    key0 = 2'b11;
    key1 = 2'b11;
    repeat (3) step();
    check_cleared("reset");
    rst = 1'b0;
    step();

    // Single key[0] press on the free-running instance, cycle-exact latency.
    key0 = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("t1_early", kp0, 2'b00);
    end
    step();
    check("t1_press", kp0, 2'b01);
    check("t1_level", kl0, 2'b01);
    check("t1_pend_n13", mp0, 2'd0);
    step();
    check("t1_press_off", kp0, 2'b00);
    check("t1_pend", mp0, 2'd1);
    check("t1_mode_n14", m0, 2'd0);
    check("t1_upd_n14", {1'b0, mu0}, 2'b00);
    step();
    check("t1_mode", m0, 2'd1);
    check("t1_upd", {1'b0, mu0}, 2'b01);
    step();
    check("t1_upd_off", {1'b0, mu0}, 2'b00);
    release_keys("t1");

    // Bounce: low 5 cycles, high 1, then low stable from edge M.
    key0 = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bnc_pre", kp0, 2'b00);
    end
    key0 = 2'b11;
    step();
    check("bnc_high", kp0, 2'b00);
    key0 = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("bnc_early", kp0, 2'b00);
    end
    step();
    check("bnc_press", kp0, 2'b01);
    step();
    check("bnc_pend", mp0, 2'd2);
    release_keys("bnc");

    // Wrap in both directions, then a simultaneous press.
    press(1'b0, 2'b10, 2'b01, 2'd3, "up3");
    press(1'b0, 2'b10, 2'b01, 2'd0, "up_wrap0");
    press(1'b0, 2'b01, 2'b10, 2'd3, "dn_wrap3");
    press(1'b0, 2'b01, 2'b10, 2'd2, "dn2");
    press(1'b0, 2'b00, 2'b11, 2'd2, "both");
    check("fs0_mode_follows", m0, 2'd2);

    // Frame-synchronised instance: two presses, mode held until frame_start.
    press(1'b1, 2'b10, 2'b01, 2'd1, "fs1_a");
    press(1'b1, 2'b10, 2'b01, 2'd2, "fs1_b");
    check("fs1_mode_held", m1, 2'd0);
    check("fs1_upd_held", {1'b0, mu1}, 2'b00);
    fs = 1'b1;
    step();
    fs = 1'b0;
    check("fs1_mode_jump", m1, 2'd2);
    check("fs1_upd", {1'b0, mu1}, 2'b01);
    step();
    check("fs1_upd_off", {1'b0, mu1}, 2'b00);
    fs = 1'b1;
    step();
    fs = 1'b0;
    check("fs1_same_mode", m1, 2'd2);
    check("fs1_same_no_upd", {1'b0, mu1}, 2'b00);

    // Reset mid-filter with key[0] still held through and after reset.
    key0 = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rmid_pre", kp0, 2'b00);
    end
    rst = 1'b1;
    step();
    check_cleared("rmid");
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("rmid_early", kp0, 2'b00);
    end
    step();
    check("rmid_press", kp0, 2'b01);
    step();
    check("rmid_pend", mp0, 2'd1);
    release_keys("rmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
